// File: rtl/mem_access_stage.sv
// MEM stage: data memory req/ack access, load alignment, MEM/WB register.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_MEM,
  input  logic            mem_read_MEM,
  input  logic            mem_write_MEM,
  input  logic [2:0]      funct3_MEM,
  input  logic [1:0]      result_set_MEM,
  input  logic            reg_write_MEM,
  input  logic [4:0]      rd_MEM,
  input  logic [XLEN-1:0] alu_result_MEM,
  input  logic [XLEN-1:0] store_data_MEM,
  input  logic [XLEN-1:0] pcPlus4_MEM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            stall_MEM,
  output logic            mem_timeout,
  output logic            valid_WB,
  output logic            reg_write_WB,
  output logic [4:0]      rd_WB,
  output logic [1:0]      result_set_WB,
  output logic [XLEN-1:0] alu_result_WB,
  output logic [XLEN-1:0] mem_data_WB,
  output logic [XLEN-1:0] pcPlus4_WB
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misaligned_WB
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_op, is_store, is_load;
  logic            misalign, access, timeout_now;
  logic [1:0]      off, size;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata, ldata;
  logic [7:0]      lbyte;
  logic [15:0]     lhalf;

  assign off      = alu_result_MEM[1:0];
  assign size     = funct3_MEM[1:0];
  assign mem_op   = valid_MEM & (mem_read_MEM | mem_write_MEM);
  assign is_store = mem_write_MEM;
  assign is_load  = mem_read_MEM & ~mem_write_MEM;

`ifdef MISALIGN_TRAP_EN
  assign misalign = mem_op &
    ((size == 2'b01) ? off[0] :
     size[1]         ? (off != 2'b00) : 1'b0);
`else
  assign misalign = 1'b0;
`endif

  assign access = mem_op & ~misalign;

  // Store byte enables and lane-replicated write data
  always_comb begin
    be    = 4'b1111;
    wdata = store_data_MEM;
    unique case (1'b1)
      size == 2'b00: begin
        be    = 4'b0001 << off;
        wdata = {(XLEN/8){store_data_MEM[7:0]}};
      end
      size == 2'b01: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wdata = {(XLEN/16){store_data_MEM[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    lbyte = dmem_rdata[{off, 3'b000} +: 8];
    lhalf = dmem_rdata[{off[1], 4'b0000} +: 16];
    ldata = dmem_rdata;
    unique case (1'b1)
      funct3_MEM == 3'b000: ldata = {{(XLEN-8){lbyte[7]}}, lbyte};
      funct3_MEM == 3'b001: ldata = {{(XLEN-16){lhalf[15]}}, lhalf};
      funct3_MEM == 3'b100: ldata = {{(XLEN-8){1'b0}}, lbyte};
      funct3_MEM == 3'b101: ldata = {{(XLEN-16){1'b0}}, lhalf};
      default: ;
    endcase
  end

  // Next state, wait counter and watchdog detection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (access && !dmem_ack) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (!access || dmem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(MAX_WAIT)) begin
          timeout_now = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stall_MEM  = ~rst & access & ~dmem_ack & ~timeout_now;
  assign dmem_req   = ~rst & access;
  assign dmem_we    = dmem_req & is_store;
  assign dmem_be    = dmem_req ? be : 4'b0000;
  assign dmem_addr  = {alu_result_MEM[XLEN-1:2], 2'b00};
  assign dmem_wdata = wdata;

  // FSM state and wait counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB pipeline register, bubbles while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout   <= 1'b0;
      valid_WB      <= 1'b0;
      reg_write_WB  <= 1'b0;
      rd_WB         <= '0;
      result_set_WB <= '0;
      alu_result_WB <= '0;
      mem_data_WB   <= '0;
      pcPlus4_WB    <= '0;
`ifdef MISALIGN_TRAP_EN
      misaligned_WB <= 1'b0;
`endif
    end else begin
      if (timeout_now) mem_timeout <= 1'b1;
      if (stall_MEM) begin
        valid_WB     <= 1'b0;
        reg_write_WB <= 1'b0;
`ifdef MISALIGN_TRAP_EN
        misaligned_WB <= 1'b0;
`endif
      end else begin
        valid_WB      <= valid_MEM;
        reg_write_WB  <= reg_write_MEM & valid_MEM & ~misalign;
        rd_WB         <= rd_MEM;
        result_set_WB <= result_set_MEM;
        alu_result_WB <= alu_result_MEM;
        pcPlus4_WB    <= pcPlus4_MEM;
        mem_data_WB   <= (access & is_load & ~timeout_now) ?
                         ldata : '0;
`ifdef MISALIGN_TRAP_EN
        misaligned_WB <= misalign;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage.
// Scoreboard of expected MEM/WB records, directed steps.
module tb_mem_access_stage;

  localparam int XLEN = 32;
  localparam int MAXW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_MEM, mem_read_MEM, mem_write_MEM;
  logic [2:0]      funct3_MEM;
  logic [1:0]      result_set_MEM;
  logic            reg_write_MEM;
  logic [4:0]      rd_MEM;
  logic [XLEN-1:0] alu_result_MEM, store_data_MEM, pcPlus4_MEM;
  logic            dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]      dmem_be;
  logic            dmem_ack;
  logic            stall_MEM, mem_timeout;
  logic            valid_WB, reg_write_WB;
  logic [4:0]      rd_WB;
  logic [1:0]      result_set_WB;
  logic [XLEN-1:0] alu_result_WB, mem_data_WB, pcPlus4_WB;
`ifdef MISALIGN_TRAP_EN
  logic            misaligned_WB;
`endif

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(XLEN), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .valid_MEM(valid_MEM), .mem_read_MEM(mem_read_MEM),
    .mem_write_MEM(mem_write_MEM), .funct3_MEM(funct3_MEM),
    .result_set_MEM(result_set_MEM), .reg_write_MEM(reg_write_MEM),
    .rd_MEM(rd_MEM), .alu_result_MEM(alu_result_MEM),
    .store_data_MEM(store_data_MEM), .pcPlus4_MEM(pcPlus4_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_MEM(stall_MEM), .mem_timeout(mem_timeout),
    .valid_WB(valid_WB), .reg_write_WB(reg_write_WB),
    .rd_WB(rd_WB), .result_set_WB(result_set_WB),
    .alu_result_WB(alu_result_WB), .mem_data_WB(mem_data_WB),
    .pcPlus4_WB(pcPlus4_WB)
`ifdef MISALIGN_TRAP_EN
    , .misaligned_WB(misaligned_WB)
`endif
  );

  typedef struct {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [31:0] pc4;
  } wb_t;

  wb_t sb_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd_en,
                       input logic wr_en, input logic [2:0] f3,
                       input logic [1:0] rs, input logic rw,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] pc4);
    @(negedge clk);
    valid_MEM      = v;
    mem_read_MEM   = rd_en;
    mem_write_MEM  = wr_en;
    funct3_MEM     = f3;
    result_set_MEM = rs;
    reg_write_MEM  = rw;
    rd_MEM         = rd;
    alu_result_MEM = alu;
    store_data_MEM = sd;
    pcPlus4_MEM    = pc4;
    dmem_ack       = 1'b0;
  endtask

  // waits < 0 means memory never acks (watchdog path)
  task automatic run(input int waits, input logic [31:0] rdata,
                     input logic [31:0] exp_md);
    int   stalls;
    logic op;
    wb_t  e, o;
    op = valid_MEM & (mem_read_MEM | mem_write_MEM);
    stalls = !op ? 0 : (waits < 0) ? MAXW : waits;
    e.valid     = valid_MEM;
    e.reg_write = reg_write_MEM & valid_MEM;
    e.rd        = rd_MEM;
    e.rs        = result_set_MEM;
    e.alu       = alu_result_MEM;
    e.mdata     = exp_md;
    e.pc4       = pcPlus4_MEM;
    sb_q.push_back(e);
    dmem_rdata = rdata;
    for (int i = 0; i <= stalls; i++) begin
      if (i > 0) @(negedge clk);
      dmem_ack = (i == waits);
      #1;
      chk("dmem_req", {31'b0, dmem_req}, {31'b0, op});
      chk("stall", {31'b0, stall_MEM}, 32'(i < stalls));
      @(posedge clk);
      #1;
      if (i < stalls) begin
        chk("bubble_valid", {31'b0, valid_WB}, 32'd0);
      end else if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        o = sb_q.pop_front();
        chk("valid_WB", {31'b0, valid_WB}, {31'b0, o.valid});
        chk("reg_write_WB", {31'b0, reg_write_WB},
            {31'b0, o.reg_write});
        chk("rd_WB", {27'b0, rd_WB}, {27'b0, o.rd});
        chk("result_set_WB", {30'b0, result_set_WB}, {30'b0, o.rs});
        chk("alu_result_WB", alu_result_WB, o.alu);
        chk("mem_data_WB", mem_data_WB, o.mdata);
        chk("pcPlus4_WB", pcPlus4_WB, o.pc4);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    valid_MEM = 0; mem_read_MEM = 0; mem_write_MEM = 0;
    funct3_MEM = 0; result_set_MEM = 0; reg_write_MEM = 0;
    rd_MEM = 0; alu_result_MEM = 0; store_data_MEM = 0;
    pcPlus4_MEM = 0; dmem_rdata = 0; dmem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_WB", {31'b0, valid_WB}, 32'd0);
    chk("rst_alu_WB", alu_result_WB, 32'd0);
    chk("rst_timeout", {31'b0, mem_timeout}, 32'd0);
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU op
    drive(1, 0, 0, 3'b000, 2'b00, 1, 5'd5, 32'h1234, 0, 32'h104);
    run(0, 32'h0, 32'h0);

    // LB / LBU with two wait cycles
    drive(1, 1, 0, 3'b000, 2'b01, 1, 5'd6, 32'h103, 0, 32'h108);
    #1 chk("lb_addr", dmem_addr, 32'h100);
    run(2, 32'h80FF_FF00, 32'hFFFF_FF80);
    drive(1, 1, 0, 3'b100, 2'b01, 1, 5'd7, 32'h103, 0, 32'h10C);
    run(2, 32'h80FF_FF00, 32'h0000_0080);

    // LH / LHU
    drive(1, 1, 0, 3'b001, 2'b01, 1, 5'd8, 32'h102, 0, 32'h110);
    run(1, 32'h8001_1234, 32'hFFFF_8001);
    drive(1, 1, 0, 3'b101, 2'b01, 1, 5'd9, 32'h100, 0, 32'h114);
    run(0, 32'h8001_1234, 32'h0000_1234);

    // SH zero-wait
    drive(1, 0, 1, 3'b001, 2'b00, 0, 5'd0, 32'h202,
          32'h0000_ABCD, 32'h118);
    #1;
    chk("sh_be", {28'b0, dmem_be}, 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_we", {31'b0, dmem_we}, 32'd1);
    run(0, 32'h0, 32'h0);

    // SB and SW lanes
    drive(1, 0, 1, 3'b000, 2'b00, 0, 5'd0, 32'h101,
          32'h1234_56A5, 32'h11C);
    #1;
    chk("sb_be", {28'b0, dmem_be}, 32'b0010);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    run(1, 32'h0, 32'h0);
    drive(1, 0, 1, 3'b010, 2'b00, 0, 5'd0, 32'h104,
          32'hCAFE_F00D, 32'h120);
    #1;
    chk("sw_be", {28'b0, dmem_be}, 32'b1111);
    chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
    chk("sw_addr", dmem_addr, 32'h104);
    run(0, 32'h0, 32'h0);
    chk("timeout_clear", {31'b0, mem_timeout}, 32'd0);

    // LW watchdog timeout then pipe resumes
    drive(1, 1, 0, 3'b010, 2'b01, 1, 5'd10, 32'h300, 0, 32'h124);
    run(-1, 32'h5555_5555, 32'h0);
    chk("timeout_set", {31'b0, mem_timeout}, 32'd1);
    drive(1, 0, 0, 3'b000, 2'b00, 1, 5'd11, 32'h9876, 0, 32'h128);
    run(0, 32'h0, 32'h0);

    // Reset during WAIT, then stray ack
    drive(1, 1, 0, 3'b010, 2'b01, 1, 5'd12, 32'h400, 0, 32'h12C);
    #1 chk("pre_rst_stall", {31'b0, stall_MEM}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_wait_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_wait_stall", {31'b0, stall_MEM}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst2_valid_WB", {31'b0, valid_WB}, 32'd0);
    chk("rst2_alu_WB", alu_result_WB, 32'd0);
    chk("rst2_rd_WB", {27'b0, rd_WB}, 32'd0);
    chk("rst2_pc4_WB", pcPlus4_WB, 32'd0);
    chk("rst2_timeout", {31'b0, mem_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    valid_MEM = 1'b0;
    dmem_ack = 1'b1;
    #1 chk("stray_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("stray_valid_WB", {31'b0, valid_WB}, 32'd0);
    chk("stray_rw_WB", {31'b0, reg_write_WB}, 32'd0);

    // Load after reset completes normally from IDLE
    drive(1, 1, 0, 3'b010, 2'b01, 1, 5'd13, 32'h500, 0, 32'h130);
    run(1, 32'h0BAD_F00D, 32'h0BAD_F00D);

    // Misaligned LW
`ifdef MISALIGN_TRAP_EN
    drive(1, 1, 0, 3'b010, 2'b01, 1, 5'd14, 32'h101, 0, 32'h134);
    #1;
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_stall", {31'b0, stall_MEM}, 32'd0);
    @(posedge clk);
    #1;
    chk("mis_valid_WB", {31'b0, valid_WB}, 32'd1);
    chk("mis_rw_WB", {31'b0, reg_write_WB}, 32'd0);
    chk("mis_flag_WB", {31'b0, misaligned_WB}, 32'd1);
`else
    drive(1, 1, 0, 3'b010, 2'b01, 1, 5'd14, 32'h101, 0, 32'h134);
    #1 chk("mis_addr", dmem_addr, 32'h100);
    run(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
`endif

    @(negedge clk);
    valid_MEM = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RISC-V core; drives the MEM/WB pipeline register that the writeback stage consumes.
- Issues loads and stores to data memory over a req/ack handshake. Stalls the front of the pipe until memory responds.
- Aligns and sign- or zero-extends load data, then registers the result_set, alu_result, mem_data and pcPlus4 fields for writeback.

Parameters:
- XLEN, 32, datapath and address width.
- MAX_WAIT, 255, watchdog limit in cycles for dmem_ack; width of the wait counter is clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_MEM  in  1  EX/MEM holds a live instruction
- mem_read_MEM  in  1  load
- mem_write_MEM  in  1  store
- funct3_MEM  in  3  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- result_set_MEM  in  2  writeback select; passed through
- reg_write_MEM  in  1  register write enable; passed through
- rd_MEM  in  5  destination register
- alu_result_MEM  in  XLEN  effective address or ALU result
- store_data_MEM  in  XLEN  rs2 value for stores
- pcPlus4_MEM  in  XLEN  PC+4
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  XLEN  word address, {alu_result[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_rdata  in  XLEN  read word
- dmem_ack  in  1  transfer complete
- stall_MEM  out  1  freeze IF/ID/EX and EX/MEM
- mem_timeout  out  1  sticky watchdog flag
- valid_WB, reg_write_WB  out  1 each  MEM/WB register
- rd_WB  out  5  MEM/WB register
- result_set_WB  out  2  MEM/WB register
- alu_result_WB, mem_data_WB, pcPlus4_WB  out  XLEN each  MEM/WB register

Behaviour:
- Reset (sync, rst=1 at posedge):
  - All *_WB outputs are 0; mem_timeout is 0.
  - FSM goes to IDLE; wait counter is 0.
  - dmem_req, dmem_we, dmem_be and stall_MEM are 0 while rst=1.
  - An outstanding access is abandoned; a late dmem_ack after reset is ignored in IDLE unless a new request is present.
- mem_op = valid_MEM & (mem_read_MEM | mem_write_MEM). If both read and write are set, the access is treated as a store.
- FSM states:
  - IDLE: dmem_req = mem_op (combinational).
    - If mem_op & dmem_ack: zero-wait completion, stay in IDLE.
    - If mem_op & !dmem_ack: go to WAIT.
  - WAIT: dmem_req = 1; address, data, we and be are held stable from the unchanged EX/MEM inputs. Counter increments each cycle.
    - dmem_ack: go to IDLE.
    - Counter = MAX_WAIT: set mem_timeout, go to IDLE, complete with mem_data = 0.
- stall_MEM = mem_op & !dmem_ack & !timeout_now. Upstream holds EX/MEM stable while it is high.
- MEM/WB update at each posedge when not in reset:
  - If stall_MEM: valid_WB = 0 and reg_write_WB = 0 (bubble); other fields are don't-care but held.
  - Otherwise: all fields load from the *_MEM inputs. valid_WB = valid_MEM. reg_write_WB = reg_write_MEM & valid_MEM. mem_data_WB = extended load data (0 for non-loads).
- Latency: non-memory op takes 1 cycle. Memory op takes 1 + number of wait cycles before ack.
- Store lanes (offset = addr[1:0]):
  - SB: be = 0001 << off; wdata = byte replicated x4.
  - SH: be = 0011 << (off & 2); wdata = halfword replicated x2.
  - SW: be = 1111.
- Load extraction:
  - Byte = rdata[8*off +: 8]. Halfword = rdata[16*off[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word.
  - Unknown funct3 behaves as LW.
- dmem_ack while dmem_req = 0 is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned_WB (1 bit, reset 0).
  - An LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, issues no dmem_req and does not stall.
  - It writes valid_WB = 1, reg_write_WB = 0, misaligned_WB = 1.
- Undefined:
  - The port is absent.
  - Misaligned accesses use the lane rules above (low address bits are truncated by the masking).

Test Plan:
- ALU op: valid, no mem, alu_result 0x0000_1234, result_set 00 -> next cycle alu_result_WB 0x1234, valid_WB 1, dmem_req never 1, stall_MEM 0.
- LB at addr 0x103, ack with 2 wait cycles, rdata 0x80FF_FF00 -> stall_MEM high 2 cycles with bubbles on WB. Then mem_data_WB 0xFFFF_FF80; with LBU instead, 0x0000_0080.
- SH at 0x202, data 0x0000_ABCD, zero-wait ack -> dmem_be 1100, dmem_wdata 0xABCD_ABCD, dmem_addr 0x200, dmem_we 1, no stall.
- LW with ack held 0 and MAX_WAIT=4 -> stall for 4 cycles, mem_timeout set, mem_data_WB 0, pipe resumes.
- Assert rst during WAIT -> next cycle all WB outputs 0, dmem_req 0, FSM IDLE. A later stray ack produces no WB update.
- With MISALIGN_TRAP_EN: LW at 0x101 -> no dmem_req, misaligned_WB 1, reg_write_WB 0.
